// File: rtl/odd_clk_divider.sv
// rtl/odd_clk_divider.sv - odd-ratio clock divider with exact 50% duty cycle
module odd_clk_divider #(
    parameter int dividor   = 5,
    parameter int CNT_WIDTH = $clog2(dividor - 1)
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
);

    // Counter must always hold dividor-1, whatever CNT_WIDTH the integrator passed.
    localparam int CW = (CNT_WIDTH > $clog2(dividor)) ? CNT_WIDTH : $clog2(dividor);

    localparam logic [CW-1:0] CNT_LAST = CW'(dividor - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((dividor - 1) / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Only odd ratios of at least 3 can produce a symmetric waveform this way.
    generate
        if ((dividor < 3) || ((dividor % 2) == 0)) begin : g_bad_dividor
            $error("odd_clk_divider: dividor must be odd and >= 3");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_p_q;
    logic          clk_p_d;
    logic          clk_n_q;

    // Next count wraps at dividor-1; the posedge phase is high for the first (N+1)/2 counts.
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNT_ONE);
        clk_p_d = (cnt_d <= CNT_HALF);
    end

    // Posedge state: counter and posedge phase flop; reset parks the counter so the
    // first non-reset edge lands on count 0 with the phase high.
    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            cnt_q   <= CNT_LAST;
            clk_p_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_p_q <= clk_p_d;
        end
    end

    // Negedge copy of the posedge phase, half an input cycle late.
    always_ff @(negedge clk_in) begin
        if (rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_p_q;
        end
    end

    // Rises with the negedge copy and falls with the posedge phase; only one input
    // of the AND moves at any edge, so the output cannot glitch.
    assign clk_out = clk_p_q & clk_n_q;

endmodule

// File: tb/tb_odd_clk_divider.sv
// tb/tb_odd_clk_divider.sv - directed self-checking bench for odd_clk_divider
`timescale 1ns/1ps
module tb_odd_clk_divider;

    localparam int NS = 400;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    logic o5, o3, o7, o9;
    logic [3:0] o_all;

    int total = 0;
    int bad   = 0;

    logic s5 [NS];
    logic s3 [NS];
    logic s7 [NS];
    logic s9 [NS];
    int   c9 [NS/2];
    int   nn [4] = '{5, 3, 7, 9};

    logic mon_en    = 1'b0;
    logic mon_first = 1'b0;
    time  last_t    = 0;
    int   hi_w[$];
    int   lo_w[$];

    always #5 clk_in = ~clk_in;

    odd_clk_divider #(.dividor(5)) u_d5 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o5));
    odd_clk_divider #(.dividor(3)) u_d3 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o3));
    odd_clk_divider #(.dividor(7)) u_d7 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o7));
    odd_clk_divider #(.dividor(9)) u_d9 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o9));

    assign o_all = {o9, o7, o3, o5};

    always @(o5) begin
        if (mon_en) begin
            if (mon_first) begin
                mon_first = 1'b0;
            end else if (o5 === 1'b0) begin
                hi_w.push_back(int'($time - last_t));
            end else begin
                lo_w.push_back(int'($time - last_t));
            end
            last_t = $time;
        end
    end

    task automatic next_slot();
        @(clk_in);
        #1;
    endtask

    // h = half-cycle slot index, 0 = just after the first non-reset posedge
    function automatic logic exp_out(int h, int n);
        if (h <= 0) return 1'b0;
        return ((((h - 1) / n) % 2) == 0);
    endfunction

    task automatic test_reset();
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (o_all[j] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_low n=%0d slot=%0d got=%b want=0", nn[j], i, o_all[j]);
                end
            end
            if (i != 19) next_slot();
        end
        #1 rst_n = 1'b0;
    endtask

    task automatic test_div5();
        int rises;
        int glitches;
        @(posedge clk_in);
        #1;
        mon_en    = 1'b1;
        mon_first = 1'b1;
        last_t    = $time;
        for (int h = 0; h < NS; h++) begin
            s5[h] = o5;
            s3[h] = o3;
            s7[h] = o7;
            s9[h] = o9;
            if ((h % 2) == 0) c9[h/2] = int'(u_d9.cnt_q);
            total++;
            if (s5[h] !== exp_out(h, 5)) begin
                bad++;
                $display("FAIL wave_n5 slot=%0d got=%b want=%b", h, s5[h], exp_out(h, 5));
            end
            if (h != NS - 1) next_slot();
        end
        mon_en = 1'b0;
        rises = 0;
        for (int h = 1; h < NS; h++) if (s5[h] === 1'b1 && s5[h-1] === 1'b0) rises++;
        total++;
        if (rises !== 40) begin
            bad++;
            $display("FAIL rises_n5 got=%0d want=40", rises);
        end
        total++;
        if (hi_w.size() !== 40) begin
            bad++;
            $display("FAIL high_phases_n5 got=%0d want=40", hi_w.size());
        end
        total++;
        if (lo_w.size() !== 39) begin
            bad++;
            $display("FAIL low_phases_n5 got=%0d want=39", lo_w.size());
        end
        glitches = 0;
        foreach (hi_w[i]) begin
            if (hi_w[i] < 5) glitches++;
            total++;
            if (hi_w[i] !== 25) begin
                bad++;
                $display("FAIL high_width_n5 idx=%0d got=%0dns want=25ns", i, hi_w[i]);
            end
        end
        foreach (lo_w[i]) begin
            if (lo_w[i] < 5) glitches++;
            total++;
            if (lo_w[i] !== 25) begin
                bad++;
                $display("FAIL low_width_n5 idx=%0d got=%0dns want=25ns", i, lo_w[i]);
            end
        end
        total++;
        if (glitches !== 0) begin
            bad++;
            $display("FAIL glitch_n5 got=%0d want=0", glitches);
        end
    endtask

    task automatic test_div3_7();
        int r3;
        int r7;
        r3 = 0;
        r7 = 0;
        for (int h = 0; h < NS; h++) begin
            total++;
            if (s3[h] !== exp_out(h, 3)) begin
                bad++;
                $display("FAIL wave_n3 slot=%0d got=%b want=%b", h, s3[h], exp_out(h, 3));
            end
            total++;
            if (s7[h] !== exp_out(h, 7)) begin
                bad++;
                $display("FAIL wave_n7 slot=%0d got=%b want=%b", h, s7[h], exp_out(h, 7));
            end
            if (h > 0 && s3[h] === 1'b1 && s3[h-1] === 1'b0) r3++;
            if (h > 0 && s7[h] === 1'b1 && s7[h-1] === 1'b0) r7++;
        end
        total++;
        if (r3 !== 67) begin
            bad++;
            $display("FAIL rises_n3 got=%0d want=67", r3);
        end
        total++;
        if (r7 !== 29) begin
            bad++;
            $display("FAIL rises_n7 got=%0d want=29", r7);
        end
    endtask

    task automatic test_div9();
        int r9;
        int mx;
        r9 = 0;
        mx = 0;
        for (int h = 0; h < NS; h++) begin
            total++;
            if (s9[h] !== exp_out(h, 9)) begin
                bad++;
                $display("FAIL wave_n9 slot=%0d got=%b want=%b", h, s9[h], exp_out(h, 9));
            end
            if (h > 0 && s9[h] === 1'b1 && s9[h-1] === 1'b0) r9++;
        end
        for (int j = 0; j < NS/2; j++) begin
            if (c9[j] > mx) mx = c9[j];
            total++;
            if (c9[j] !== (j % 9)) begin
                bad++;
                $display("FAIL cnt_n9 edge=%0d got=%0d want=%0d", j, c9[j], j % 9);
            end
        end
        total++;
        if (mx !== 8) begin
            bad++;
            $display("FAIL cnt_max_n9 got=%0d want=8", mx);
        end
        total++;
        if (r9 !== 23) begin
            bad++;
            $display("FAIL rises_n9 got=%0d want=23", r9);
        end
    endtask

    task automatic test_mid_reset();
        for (int h = NS; h < NS + 4; h++) begin
            next_slot();
            total++;
            if (o5 !== exp_out(h, 5)) begin
                bad++;
                $display("FAIL pre_reset_n5 slot=%0d got=%b want=%b", h, o5, exp_out(h, 5));
            end
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_slot();
            for (int j = 0; j < 4; j++) begin
                total++;
                if (o_all[j] !== 1'b0) begin
                    bad++;
                    $display("FAIL mid_reset_low n=%0d slot=%0d got=%b want=0", nn[j], k, o_all[j]);
                end
            end
        end
        #1 rst_n = 1'b0;
        @(posedge clk_in);
        #1;
        for (int h = 0; h < 60; h++) begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (o_all[j] !== exp_out(h, nn[j])) begin
                    bad++;
                    $display("FAIL restart n=%0d slot=%0d got=%b want=%b", nn[j], h, o_all[j], exp_out(h, nn[j]));
                end
            end
            if (h != 59) next_slot();
        end
    endtask

    initial begin
        test_reset();
        test_div5();
        test_div3_7();
        test_div9();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
